mux_n_pipe: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with a registered, valid/ready-handshaked output stage.
- Successor of the 2-input combinational data selector; used on datapath paths that cross a pipeline boundary, e.g. writeback source select and ALU operand forwarding.
- Holds the selected word plus the select index that produced it.
- Contains a 2-entry skid buffer, so upstream sees registered backpressure and there is no throughput loss.

---
 rtl/mux_n_pipe_pkg.sv | 9 +
 rtl/mux_n_sel.sv | 24 ++
 rtl/mux_n_pipe.sv | 95 +++++++++
 tb/tb_mux_n_pipe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// mux_n_pipe_pkg: state encoding and shared constants for mux_n_pipe
package mux_n_pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
  localparam int ERRCNT_W = 8;
endpackage

// File: rtl/mux_n_sel.sv
// mux_n_sel: combinational N-way word selector; out-of-range select yields zero and err
module mux_n_sel #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      word_o,
  output logic                  err_o
);
  logic [WIDTH-1:0] words [2**SEL_W];
  // pad the table to a power of two so every select value indexes something defined
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_w
    if (g < N_IN) begin : g_in
      assign words[g] = data_i[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end
  // extra bit keeps the compare correct when N_IN is a power of two
  assign err_o  = {1'b0, sel_i} >= (SEL_W+1)'(N_IN);
  assign word_o = err_o ? '0 : words[sel_i];
endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way selector behind a 2-entry skid buffer; MUX_N_PIPE_ERRCNT_EN adds err_cnt
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_N_PIPE_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]   err_cnt
`endif
);
  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } entry_t;
  state_t           state_q;
  entry_t           main_q, skid_q, new_e;
  logic             in_ready_q, out_valid_q, acc, tak, sel_err;
  logic [WIDTH-1:0] sel_word;
  mux_n_sel #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) u_sel (
    .data_i(in_data),
    .sel_i (in_sel),
    .word_o(sel_word),
    .err_o (sel_err)
  );
  assign new_e     = '{err: sel_err, sel: in_sel, data: sel_word};
  assign acc       = in_valid && in_ready_q;
  assign tak       = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q.data;
  assign out_sel   = main_q.sel;
  assign out_err   = main_q.err;
  // occupancy FSM; handshake flags are registered alongside the state so neither has a comb path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          main_q      <= new_e;
          state_q     <= ST_ONE;
          out_valid_q <= 1'b1;
        end
        ST_ONE: if (acc && !tak) begin
          skid_q     <= new_e;
          state_q    <= ST_TWO;
          in_ready_q <= 1'b0;
        end else if (acc) begin
          main_q <= new_e;
        end else if (tak) begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
        ST_TWO: if (tak) begin
          main_q     <= skid_q;
          state_q    <= ST_ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
`ifdef MUX_N_PIPE_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
  // saturating count of accepted out-of-range selects
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else if (acc && sel_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: scoreboard bench for mux_n_pipe (N_IN=4 main instance, N_IN=3 range instance)
module tb_mux_n_pipe;
  logic          clk = 0;
  logic          rst_n = 0;
  logic [127:0]  in_data = '0;
  logic [1:0]    in_sel = '0;
  logic          in_valid = 0, out_ready = 0;
  logic          in_ready, out_valid, out_err;
  logic [31:0]   out_data;
  logic [1:0]    out_sel;
  logic [95:0]   in_data3 = '0;
  logic [1:0]    in_sel3 = '0;
  logic          in_valid3 = 0, out_ready3 = 1;
  logic          in_ready3, out_valid3, out_err3;
  logic [31:0]   out_data3;
  logic [1:0]    out_sel3;
`ifdef MUX_N_PIPE_ERRCNT_EN
  logic [7:0]    err_cnt, err_cnt3;
`endif
  int            n_cmp = 0, n_err = 0;
  bit            mon_en = 0;
  logic [34:0]   q[$];

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .N_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_N_PIPE_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  mux_n_pipe #(.WIDTH(32), .N_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_N_PIPE_ERRCNT_EN
    , .err_cnt(err_cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [34:0] model(input logic [127:0] d, input logic [1:0] s);
    return {1'b0, s, d[s*32 +: 32]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: occupancy-derived handshake, head-of-queue compare (also covers stall stability)
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) q.delete();
      else begin
        chk("in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
        chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
        if (out_valid && q.size() != 0) begin
          chk("out_word", {29'b0, out_err, out_sel, out_data}, {29'b0, q[0]});
          if (out_ready) void'(q.pop_front());
        end
        if (in_valid && in_ready) q.push_back(model(in_data, in_sel));
      end
    end
  end

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_data", {32'b0, out_data}, 64'd0);
    chk("rst_sel_err", {61'b0, out_err, out_sel}, 64'd0);
    mon_en = 1;
    tick(); rst_n = 1;
    // basic select
    tick();
    in_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    in_sel = 2; in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("basic_valid", {63'b0, out_valid}, 64'd1);
    chk("basic_data", {32'b0, out_data}, 64'hCCCC0002);
    chk("basic_sel", {62'b0, out_sel}, 64'd2);
    chk("basic_err", {63'b0, out_err}, 64'd0);
    tick();
    @(negedge clk);
    chk("basic_drop", {63'b0, out_valid}, 64'd0);
    // streaming
    tick(); in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      tick();
      chk("stream_ready", {63'b0, in_ready}, 64'd1);
    end
    in_valid = 0;
    tick(); tick();
    // backpressure
    out_ready = 0; in_valid = 1; in_sel = 0;
    tick(); in_sel = 1;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("bp_full", {63'b0, in_ready}, 64'd0);
    chk("bp_hold_a", {32'b0, out_data}, 64'hAAAA0000);
    tick(); tick();
    chk("bp_still_a", {32'b0, out_data}, 64'hAAAA0000);
    out_ready = 1;
    tick();
    chk("bp_b_next", {32'b0, out_data}, 64'hBBBB0001);
    chk("bp_ready_back", {63'b0, in_ready}, 64'd1);
    tick(); tick();
    // reset mid-stall
    out_ready = 0; in_valid = 1; in_sel = 3;
    tick(); in_sel = 2;
    tick(); in_valid = 0;
    tick(); rst_n = 0;
    tick(); rst_n = 1;
    chk("rs_valid", {63'b0, out_valid}, 64'd0);
    chk("rs_ready", {63'b0, in_ready}, 64'd1);
    chk("rs_data", {32'b0, out_data}, 64'd0);
    out_ready = 1;
    tick(); tick();
    // random stream
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      in_sel = 2'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 0; out_ready = 1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    // out-of-range on the N_IN=3 instance
    in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    in_sel3 = 3; in_valid3 = 1;
    tick(); in_valid3 = 0;
    chk("oor_valid", {63'b0, out_valid3}, 64'd1);
    chk("oor_data", {32'b0, out_data3}, 64'd0);
    chk("oor_err", {63'b0, out_err3}, 64'd1);
    chk("oor_sel", {62'b0, out_sel3}, 64'd3);
`ifdef MUX_N_PIPE_ERRCNT_EN
    chk("errcnt_one", {56'b0, err_cnt3}, 64'd1);
`endif
    in_sel3 = 2; in_valid3 = 1;
    tick(); in_valid3 = 0;
    chk("n3_top_data", {32'b0, out_data3}, 64'h33333333);
    chk("n3_top_err", {63'b0, out_err3}, 64'd0);
`ifdef MUX_N_PIPE_ERRCNT_EN
    in_sel3 = 3; in_valid3 = 1;
    for (int i = 0; i < 300; i++) tick();
    in_valid3 = 0;
    tick();
    chk("errcnt_sat", {56'b0, err_cnt3}, 64'd255);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
